// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory write-port arbiter.
package dm_pkg;

    localparam int unsigned IDX_W_DEF      = 10;
    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_be_merge.sv
// Merges lane-aligned store data into the current DM word and flags misaligned accesses.
module dm_be_merge
    import dm_pkg::*;
(
    input  logic [3:0]  be_i,
    input  logic [1:0]  adr_lo_i,
    input  logic [31:0] wd_new_i,
    input  logic [31:0] wd_old_i,
    output logic [31:0] wd_merged_o,
    output logic        misalign_o
);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wd_merged_o[8*k +: 8] = be_i[k] ? wd_new_i[8*k +: 8] : wd_old_i[8*k +: 8];
        end
        misalign_o = ((be_i == BE_WORD) && (adr_lo_i != 2'b00)) ||
                     (((be_i == BE_HALF_LO) || (be_i == BE_HALF_HI)) && adr_lo_i[0]);
    end

endmodule

// File: rtl/dm_arbiter.sv
// Owns the DM write port: arbitrates CPU vs DMA, merges sub-word stores and sequences
// a word-by-word memory clear.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        DMC_clk_M_i,
    input  logic        DMC_ret_M_i,
    input  logic        cpu_req_M_i,
    input  logic        cpu_we_M_i,
    input  logic [3:0]  cpu_be_M_i,
    input  logic [31:0] cpu_adr_M_i,
    input  logic [31:0] cpu_wd_M_i,
    input  logic [31:0] cpu_npc_M_i,
    output logic [31:0] cpu_rd_M_o,
    output logic        cpu_stall_M_o,
    output logic        align_err_M_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_adr_i,
    input  logic [31:0] dma_wd_i,
    output logic        dma_gnt_o,
    output logic [31:0] dma_rd_o,
    output logic        dma_rvalid_o,
    input  logic        clr_i,
    output logic        clr_busy_o,
    output logic [31:0] dm_adr_o,
    output logic [31:0] dm_wtd_o,
    output logic        dm_we_o,
    output logic [31:0] dm_npc_o,
    input  logic [31:0] dm_dmd_i
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    dm_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [31:0]      dma_rd_q;
    logic             dma_rvalid_q;
    logic [31:0]      merged;
    logic             misalign;
    logic             cpu_gnt, dma_gnt;
    logic             unused_dma_lo;

    assign unused_dma_lo = ^dma_adr_i[1:0];

    dm_be_merge u_merge (
        .be_i        (cpu_be_M_i),
        .adr_lo_i    (cpu_adr_M_i[1:0]),
        .wd_new_i    (cpu_wd_M_i),
        .wd_old_i    (dm_dmd_i),
        .wd_merged_o (merged),
        .misalign_o  (misalign)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        starve_d      = starve_q;
        cpu_gnt       = 1'b0;
        dma_gnt       = 1'b0;
        dm_adr_o      = {cpu_adr_M_i[31:2], 2'b00};
        dm_wtd_o      = merged;
        dm_we_o       = 1'b0;
        dm_npc_o      = '0;
        cpu_stall_M_o = 1'b0;
        align_err_M_o = 1'b0;
        clr_busy_o    = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                dm_adr_o      = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                dm_wtd_o      = '0;
                dm_we_o       = 1'b1;
                cpu_stall_M_o = cpu_req_M_i;
                clr_busy_o    = 1'b1;
                idx_d         = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) state_d = S_IDLE;
                if (!dma_req_i) starve_d = '0;
            end
            S_IDLE: begin
                // CPU wins ties until DMA has waited STARVE_MAX consecutive CPU grants
                cpu_gnt = cpu_req_M_i && !(dma_req_i && (starve_q == SW'(STARVE_MAX)));
                dma_gnt = dma_req_i && !cpu_gnt;
                starve_d = (cpu_gnt && dma_req_i) ? starve_q + SW'(1) : '0;
                if (cpu_gnt) begin
                    dm_npc_o      = cpu_npc_M_i;
                    align_err_M_o = misalign;
                    dm_we_o       = cpu_we_M_i && !misalign;
                end else if (dma_gnt) begin
                    dm_adr_o = {dma_adr_i[31:2], 2'b00};
                    dm_wtd_o = dma_wd_i;
                    dm_we_o  = dma_we_i;
                end
                cpu_stall_M_o = cpu_req_M_i && !cpu_gnt;
                if (clr_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
        endcase
        if (DMC_ret_M_i) begin
            cpu_gnt       = 1'b0;
            dma_gnt       = 1'b0;
            dm_we_o       = 1'b0;
            cpu_stall_M_o = 1'b0;
            align_err_M_o = 1'b0;
            clr_busy_o    = 1'b0;
        end
    end

    always_ff @(posedge DMC_clk_M_i) begin
        if (DMC_ret_M_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            starve_q     <= '0;
            dma_rd_q     <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            starve_q     <= starve_d;
            dma_rvalid_q <= dma_gnt && !dma_we_i;
            if (dma_gnt && !dma_we_i) dma_rd_q <= dm_dmd_i;
        end
    end

    assign cpu_rd_M_o   = dm_dmd_i;
    assign dma_gnt_o    = dma_gnt;
    assign dma_rd_o     = dma_rd_q;
    assign dma_rvalid_o = dma_rvalid_q && !DMC_ret_M_i;

endmodule
